// File: rtl/banda_pkg.sv
// Shared constants and types for the band register and its row-scanning reader.
package banda_pkg;
  localparam int ANCHO_BANDA = 25;
  localparam int N_FILAS     = 5;
  localparam int ANCHO_FILA  = 5;
  localparam int KW          = $clog2(N_FILAS);

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    PEDIR  = 3'd1,
    ESPERA = 3'd2,
    BARRER = 3'd3,
    FIN    = 3'd4
  } estado_t;

  typedef struct packed {
    logic                  leer;
    logic [ANCHO_FILA-1:0] fila;
    logic [ANCHO_FILA-1:0] sel_fila;
    logic                  valido;
    logic                  ocupado;
    logic                  hecho;
  } salida_t;

  // Row 0 is the most significant slice of the band.
  function automatic logic [ANCHO_FILA-1:0] fila_de(input logic [ANCHO_BANDA-1:0] b,
                                                    input logic [KW-1:0] k);
    fila_de = '0;
    for (int r = 0; r < N_FILAS; r++)
      if (k == KW'(r)) fila_de = b[(N_FILAS-1-r)*ANCHO_FILA +: ANCHO_FILA];
  endfunction
endpackage

// File: rtl/lector_banda_if.sv
// Bus between the band reader and its neighbours (register, start source, display driver).
interface lector_banda_if;
  import banda_pkg::*;

  logic                   inicio;
  logic [ANCHO_BANDA-1:0] dato_banda;
  logic                   leer;
  logic [ANCHO_FILA-1:0]  fila;
  logic [ANCHO_FILA-1:0]  sel_fila;
  logic                   valido;
  logic                   ocupado;
  logic                   hecho;

  modport slave  (input  inicio, dato_banda,
                  output leer, fila, sel_fila, valido, ocupado, hecho);
  modport master (output inicio, dato_banda,
                  input  leer, fila, sel_fila, valido, ocupado, hecho);
endinterface

// File: rtl/lector_banda_contador_fila.sv
// Row dwell counter: counts 0..TIEMPO_FILA-1 while enabled and wraps, flagging the last cycle.
module contador_fila #(
  parameter int TIEMPO_FILA = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = $clog2(TIEMPO_FILA + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == W'(TIEMPO_FILA - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/reg_banda.sv
// 25-bit band register: written by its owner, published on `out` only when `leer` strobes.
module reg_banda
  import banda_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   escribir,
  input  logic [ANCHO_BANDA-1:0] dato,
  input  logic                   leer,
  output logic [ANCHO_BANDA-1:0] out
);
  logic [ANCHO_BANDA-1:0] mem_q, out_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '0;
      out_q <= '0;
    end else begin
      if (escribir) mem_q <= dato;
      if (leer)     out_q <= mem_q;
    end
  end

  assign out = out_q;
endmodule

// File: rtl/lector_banda.sv
// Band reader: strobes reg_banda once, captures the band and scans it out row by row.
module lector_banda
  import banda_pkg::*;
#(
  parameter int TIEMPO_FILA = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  lector_banda_if.slave  bus
);
  estado_t                estado_q, estado_d;
  logic [ANCHO_BANDA-1:0] buf_q, buf_d;
  logic [KW-1:0]          k_q, k_d;
  salida_t                sal_q, sal_d;
  logic                   tc, cnt_clr, cnt_en;

  contador_fila #(.TIEMPO_FILA(TIEMPO_FILA)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  always_comb begin
    estado_d = estado_q;
    buf_d    = buf_q;
    k_d      = k_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (estado_q)
      REPOSO: if (bus.inicio) estado_d = PEDIR;
      PEDIR:  estado_d = ESPERA;
      // reg_banda has refreshed `out` by now; take the snapshot for the whole scan
      ESPERA: begin
        estado_d = BARRER;
        buf_d    = bus.dato_banda;
        k_d      = '0;
        cnt_clr  = 1'b1;
      end
      BARRER: begin
        cnt_en = 1'b1;
        if (tc) begin
          if (k_q == KW'(N_FILAS - 1)) estado_d = FIN;
          else                         k_d      = k_q + KW'(1);
        end
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // Outputs are decoded from next state so every one of them comes straight off a flop.
  always_comb begin
    sal_d         = '0;
    sal_d.leer    = (estado_d == PEDIR);
    sal_d.ocupado = (estado_d != REPOSO);
    sal_d.hecho   = (estado_d == FIN);
    if (estado_d == BARRER) begin
      sal_d.valido   = 1'b1;
      sal_d.sel_fila = ANCHO_FILA'(1) << k_d;
      sal_d.fila     = fila_de(buf_d, k_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= REPOSO;
      buf_q    <= '0;
      k_q      <= '0;
      sal_q    <= '0;
    end else begin
      estado_q <= estado_d;
      buf_q    <= buf_d;
      k_q      <= k_d;
      sal_q    <= sal_d;
    end
  end

  assign bus.leer     = sal_q.leer;
  assign bus.fila     = sal_q.fila;
  assign bus.sel_fila = sal_q.sel_fila;
  assign bus.valido   = sal_q.valido;
  assign bus.ocupado  = sal_q.ocupado;
  assign bus.hecho    = sal_q.hecho;
endmodule

// File: tb/tb_lector_banda.sv
// Bench: reg_banda + lector_banda at TIEMPO_FILA=4 and =1, checked against a timeline model.
module tb_lector_banda;
  import banda_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, we = 1'b0, inicio = 1'b0, sel = 1'b0;
  logic [24:0] din = '0;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  lector_banda_if if4();
  lector_banda_if if1();
  assign if4.inicio = inicio & ~sel;
  assign if1.inicio = inicio &  sel;

  reg_banda rb4 (.clk(clk), .rst_n(rst_n), .escribir(we), .dato(din),
                 .leer(if4.leer), .out(if4.dato_banda));
  reg_banda rb1 (.clk(clk), .rst_n(rst_n), .escribir(we), .dato(din),
                 .leer(if1.leer), .out(if1.dato_banda));
  lector_banda #(.TIEMPO_FILA(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  lector_banda #(.TIEMPO_FILA(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [13:0] o4, o1, obs;
  int          tf;
  assign o4 = {if4.leer, if4.fila, if4.sel_fila, if4.valido, if4.ocupado, if4.hecho};
  assign o1 = {if1.leer, if1.fila, if1.sel_fila, if1.valido, if1.ocupado, if1.hecho};
  assign obs = sel ? o1 : o4;
  assign tf  = sel ? 1 : 4;

  // Expected outputs n cycles after the edge that samples inicio (n=0: leer cycle).
  function automatic logic [13:0] modelo(input logic [24:0] v, input int t, input int n);
    logic       l, va, oc, he;
    logic [4:0] f, s;
    int         r;
    l  = (n == 0);
    va = (n >= 2) && (n < 2 + 5*t);
    he = (n == 2 + 5*t);
    oc = (n <= 2 + 5*t);
    f  = '0;
    s  = '0;
    if (va) begin
      r = (n - 2) / t;
      f = 5'((v >> (5*(4 - r))) & 25'h1F);
      s = 5'(1 << r);
    end
    return {l, f, s, va, oc, he};
  endfunction

  task automatic write_reg(input logic [24:0] v);
    @(negedge clk); we = 1'b1; din = v;
    @(negedge clk); we = 1'b0;
  endtask

  task automatic arrancar();
    @(negedge clk); inicio = 1'b1;
    @(negedge clk); inicio = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o4, o1} !== 28'd0) begin
      n_err++; $display("FAIL reset got=%h exp=0", {o4, o1});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({o4, o1} !== 28'd0) begin
        n_err++; $display("FAIL idle i=%0d got=%h exp=0", i, {o4, o1});
      end
    end
  endtask

  task automatic test_basic();
    logic [24:0] v;
    logic [13:0] e;
    v = 25'b1111111111000000000011111;
    sel = 1'b0;
    write_reg(v);
    arrancar();
    for (int n = 0; n <= 3 + 5*4; n++) begin
      e = modelo(v, 4, n);
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL basic n=%0d got=%h exp=%h", n, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_capture();
    logic [24:0] v;
    logic [13:0] e;
    v = 25'b1100110011001100110011001;
    sel = 1'b0;
    write_reg(v);
    arrancar();
    for (int n = 0; n <= 3 + 5*4; n++) begin
      e = modelo(v, 4, n);
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL capture n=%0d got=%h exp=%h", n, obs, e);
      end
      if (n == 2 + 4) begin
        we = 1'b1; din = 25'b0011001100110011001100110;
      end else we = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_t1();
    logic [24:0] v;
    logic [13:0] e;
    v = 25'b1010101010101010101010101;
    sel = 1'b1;
    write_reg(v);
    arrancar();
    for (int n = 0; n <= 3 + 5; n++) begin
      e = modelo(v, 1, n);
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL t1 n=%0d got=%h exp=%h", n, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start();
    logic [24:0] v;
    logic [13:0] e;
    v = 25'($urandom);
    sel = 1'b0;
    write_reg(v);
    arrancar();
    for (int n = 0; n <= 3 + 5*4; n++) begin
      e = modelo(v, 4, n);
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL ignored n=%0d got=%h exp=%h", n, obs, e);
      end
      inicio = (n == 2 + 2*4);
      @(negedge clk);
    end
    inicio = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [24:0] v;
    logic [13:0] e;
    int          p;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      v = 25'($urandom);
      write_reg(v);
      p = 4 + 5*tf;
      @(negedge clk); inicio = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 2*p; n++) begin
        e = modelo(v, tf, n % p);
        n_cmp++;
        if (obs !== e) begin
          n_err++; $display("FAIL b2b t=%0d n=%0d got=%h exp=%h", tf, n, obs, e);
        end
        if (n == 2*p - 1) inicio = 1'b0;
        @(negedge clk);
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [24:0] v;
    logic [13:0] e;
    v = 25'($urandom);
    sel = 1'b0;
    write_reg(v);
    arrancar();
    for (int n = 0; n <= 3 + 2*4; n++) begin
      e = modelo(v, 4, n);
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL rstmid n=%0d got=%h exp=%h", n, obs, e);
      end
      if (n == 3 + 2*4) rst_n = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (obs !== 14'd0) begin
      n_err++; $display("FAIL rstmid_zero got=%h exp=0", obs);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== 14'd0) begin
        n_err++; $display("FAIL rstmid_quiet i=%0d got=%h exp=0", i, obs);
      end
    end
    v = 25'($urandom);
    write_reg(v);
    arrancar();
    for (int n = 0; n <= 3 + 5*4; n++) begin
      e = modelo(v, 4, n);
      n_cmp++;
      if (obs !== e) begin
        n_err++; $display("FAIL rstmid_rescan n=%0d got=%h exp=%h", n, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [24:0] v;
    logic [13:0] e;
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 3; j++) begin
        sel = s[0];
        v = 25'($urandom);
        write_reg(v);
        arrancar();
        for (int n = 0; n <= 3 + 5*tf; n++) begin
          e = modelo(v, tf, n);
          n_cmp++;
          if (obs !== e) begin
            n_err++; $display("FAIL random t=%0d v=%h n=%0d got=%h exp=%h", tf, v, n, obs, e);
          end
          @(negedge clk);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_capture();
    test_t1();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lector_banda.md
# lector_banda

Reader side of the 25-bit band register `reg_banda`. On request it issues a one-cycle `leer` strobe to the register, captures the register's `out` bus, and scans the captured band out as five 5-bit rows with a one-hot row select, holding each row for a programmable number of cycles. It sits between `reg_banda` and the row-scanned display driver and is the only agent that asserts `leer`.

## Interface
- `TIEMPO_FILA`, default 4: cycles each row is held; legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `inicio`  in  1  start request; sampled only in REPOSO.
- `dato_banda`  in  25  connects to `reg_banda.out`.
- `leer`  out  1  read strobe to `reg_banda.leer`; high exactly one cycle per scan.
- `fila`  out  5  current row bits.
- `sel_fila`  out  5  one-hot row select; bit k set while row k is driven.
- `valido`  out  1  high while `fila`/`sel_fila` carry a row.
- `ocupado`  out  1  high in every state except REPOSO.
- `hecho`  out  1  one-cycle pulse after the last row.

## Operation
- Single clock, synchronous active-low reset. Reset drives state REPOSO; `leer`, `fila`, `sel_fila`, `valido`, `ocupado`, `hecho` all 0; capture buffer, row index and dwell counter cleared.
- States:
  - REPOSO: `inicio`=1 -> PEDIR; otherwise stay.
  - PEDIR: `leer`=1 for this one cycle -> ESPERA.
  - ESPERA: `reg_banda` updates `out` on the edge ending PEDIR; buffer loads `dato_banda` on the edge ending ESPERA -> BARRER with row index 0, dwell counter 0.
  - BARRER: drive row k; dwell counter increments each cycle; at TIEMPO_FILA-1, counter returns to 0 and k increments; after row 4 completes -> FIN.
  - FIN: `hecho`=1 for one cycle -> REPOSO.
- Row mapping: row k = buffer[24-5k : 20-5k]. Row 0 = bits [24:20] (MSB first); row 4 = bits [4:0].
- `sel_fila` = 1<<k during BARRER, 0 otherwise; `fila` = 0 outside BARRER.
- `dato_banda` changes after capture have no effect on the scan in progress.
- `inicio` in any state other than REPOSO is ignored, not queued. `inicio` held high continuously restarts a new scan from the REPOSO cycle that follows FIN.
- Reset asserted mid-scan: next edge returns to REPOSO with reset values; no `hecho` is issued for the aborted scan.

## Timing
- Edge E0 samples `inicio`=1 in REPOSO. `leer` is high in cycle E0–E1. Row 0 is valid from E2.
- Each row is valid for exactly TIEMPO_FILA cycles; rows are back-to-back with no gap.
- `hecho` is high in cycle E2+5·TIEMPO_FILA to E3+5·TIEMPO_FILA.
- Scan length from `inicio` sample to return to REPOSO: 3 + 5·TIEMPO_FILA cycles.
- `ocupado` is high from E0 until `hecho` falls. All outputs are registered.

## Structure
- Shared package `banda_pkg` holds:
  - ANCHO_BANDA=25, N_FILAS=5, ANCHO_FILA=5;
  - the state enum {REPOSO, PEDIR, ESPERA, BARRER, FIN}.
  `reg_banda` also uses the width constants from this package.
- One sub-module, `contador_fila`: dwell counter sized ceil(log2(TIEMPO_FILA+1)) bits, with clear and terminal-count outputs. The FSM, capture buffer and row mux stay in `lector_banda`.
- Bench instantiates `reg_banda` + `lector_banda` together, wired `leer`/`out`.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles, then 1 with `inicio`=0 for 20 cycles -> all outputs 0 and `leer` never rises.
- Basic scan, TIEMPO_FILA=4:
  - Stimulus: write 25'b1111111111000000000011111 into `reg_banda`, then pulse `inicio`.
  - Required: `leer` high for 1 cycle; rows 5'h1F, 5'h1F, 5'h00, 5'h00, 5'h1F, each for 4 cycles, with `sel_fila` 00001, 00010, 00100, 01000, 10000.
  - `hecho` at cycle 23 after the `inicio` sample.
- Capture isolation: start a scan of 25'b1100110011001100110011001, then overwrite `reg_banda` with 25'b0011001100110011001100110 during row 1. Required rows: 5'h19, 5'h13, 5'h06, 5'h0C, 5'h19 (first value throughout).
- TIEMPO_FILA=1: scan 25'b1010101010101010101010101 -> rows 5'h15, 5'h0A, 5'h15, 5'h0A, 5'h15 on consecutive cycles; `hecho` 8 cycles after the `inicio` sample.
- Ignored start: pulse `inicio` during BARRER -> no second `leer`, scan unchanged. With `inicio` held high, back-to-back scans are separated by exactly one REPOSO cycle.
- Reset mid-scan: assert `rst_n`=0 during row 2 -> next edge all outputs 0, no `hecho`; a new `inicio` after release performs a full normal scan.
